// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl
//   Miss-refill engine between the instruction cache and the instruction
//   memory read port. A cache miss on PcIn starts a burst of PREFETCH_DEPTH
//   sequential word reads from the word-aligned miss PC. The burst issues one
//   read request at a time. Each OKAY response is forwarded to the cache as a
//   single-cycle write strobe.
//
// Ports
//   Clk, Rst        clock (rising edge) and asynchronous active-high reset
//   PcIn            current fetch PC, the same PC the cache looks up
//   CacheMissing    cache miss indication for PcIn
//   FlushIn         pipeline redirect; the current refill is abandoned
//   MemArValid/MemArAddr/MemArReady   read-address channel
//   MemRValid/MemRData/MemRResp/MemRReady  read-data channel (resp 00 = OKAY)
//   RefillValid/RefillAddr/RefillInst write strobe, word address and data to the cache
//   RefillBusy      high while a refill is in progress
//   RefillError     one-cycle pulse when a response carries an error
//   DbgState        current FSM state, for debug and checkers
//
// Handshake rule (both memory channels): a transfer happens on a rising edge
// where valid and ready are both high. Once raised, MemArValid and MemArAddr
// stay constant until that transfer, and a flush does not withdraw them.
// MemRReady is only high while waiting for the single outstanding response.
module icache_refill_ctrl #(
    parameter int ADDR_W         = 64,
    parameter int INST_W         = 32,
    parameter int PREFETCH_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] PcIn,
    input  logic              CacheMissing,
    input  logic              FlushIn,
    output logic              MemArValid,
    output logic [ADDR_W-1:0] MemArAddr,
    input  logic              MemArReady,
    input  logic              MemRValid,
    input  logic [INST_W-1:0] MemRData,
    input  logic [1:0]        MemRResp,
    output logic              MemRReady,
    output logic              RefillValid,
    output logic [ADDR_W-1:0] RefillAddr,
    output logic [INST_W-1:0] RefillInst,
    output logic              RefillBusy,
    output logic              RefillError,
    output logic [1:0]        DbgState
);

    localparam int CNT_W = (PREFETCH_DEPTH > 1) ? $clog2(PREFETCH_DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(PREFETCH_DEPTH - 1);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  base;
    logic [CNT_W-1:0]   count;
    logic               drop;

    logic               trigger;
    logic               respOkay;
    logic [ADDR_W-1:0]  alignedPc;
    logic [ADDR_W-1:0]  curAddr;
    logic [ADDR_W-1:0]  nextAddr;

    // RefillValid high in IDLE means the last word is being written this
    // cycle; the cache still reports a miss for it, so do not restart.
    assign trigger   = CacheMissing & ~FlushIn & ~RefillValid;
    assign respOkay  = (MemRResp == 2'b00);
    assign alignedPc = PcIn & ALIGN_MASK;
    // Address arithmetic wraps naturally at the top of the address space.
    assign curAddr   = base + (ADDR_W'(count) << 2);
    assign nextAddr  = base + (ADDR_W'(count + CNT_ONE) << 2);
    assign DbgState  = state;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            base        <= '0;
            count       <= '0;
            drop        <= 1'b0;
            MemArValid  <= 1'b0;
            MemArAddr   <= '0;
            MemRReady   <= 1'b0;
            RefillValid <= 1'b0;
            RefillAddr  <= '0;
            RefillInst  <= '0;
            RefillBusy  <= 1'b0;
            RefillError <= 1'b0;
        end else begin
            // Cache-side outputs are single-cycle pulses unless set below.
            RefillValid <= 1'b0;
            RefillAddr  <= '0;
            RefillInst  <= '0;
            RefillError <= 1'b0;

            case (state)
                IDLE: begin
                    if (trigger) begin
                        base       <= alignedPc;
                        count      <= '0;
                        drop       <= 1'b0;
                        MemArValid <= 1'b1;
                        MemArAddr  <= alignedPc;
                        RefillBusy <= 1'b1;
                        state      <= REQ;
                    end
                end

                REQ: begin
                    if (FlushIn) begin
                        drop <= 1'b1;
                    end
                    if (MemArReady) begin
                        MemArValid <= 1'b0;
                        MemArAddr  <= '0;
                        MemRReady  <= 1'b1;
                        state      <= WAIT;
                    end
                end

                WAIT: begin
                    if (MemRValid) begin
                        MemRReady <= 1'b0;
                        if (respOkay && !drop && !FlushIn) begin
                            RefillValid <= 1'b1;
                            RefillAddr  <= curAddr;
                            RefillInst  <= MemRData;
                        end
                        if (!respOkay) begin
                            RefillError <= 1'b1;
                            RefillBusy  <= 1'b0;
                            state       <= IDLE;
                        end else if (count == CNT_LAST || drop || FlushIn) begin
                            RefillBusy <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            count      <= count + CNT_ONE;
                            MemArValid <= 1'b1;
                            MemArAddr  <= nextAddr;
                            state      <= REQ;
                        end
                    end else if (FlushIn) begin
                        // Remember the flush; the outstanding response is
                        // still drained but not written.
                        drop <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Testbench for icache_refill_ctrl. Inputs are driven and outputs sampled on
// the falling edge; the DUT samples inputs on the rising edge. The bench acts
// as the instruction memory and as the cache, and predicts every read address
// and refill write from the miss PC and the chosen memory behaviour.
module tb_icache_refill_ctrl;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;

    logic              Clk;
    logic              Rst;
    logic [ADDR_W-1:0] PcIn;
    logic              CacheMissing;
    logic              FlushIn;
    logic              MemArValid;
    logic [ADDR_W-1:0] MemArAddr;
    logic              MemArReady;
    logic              MemRValid;
    logic [INST_W-1:0] MemRData;
    logic [1:0]        MemRResp;
    logic              MemRReady;
    logic              RefillValid;
    logic [ADDR_W-1:0] RefillAddr;
    logic [INST_W-1:0] RefillInst;
    logic              RefillBusy;
    logic              RefillError;
    logic [1:0]        DbgState;

    int checks = 0;
    int errors = 0;

    // Scoreboard of expected cache writes (address, data).
    logic [ADDR_W-1:0] exp_q[$];
    logic [INST_W-1:0] expInst_q[$];

    icache_refill_ctrl #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W),
        .PREFETCH_DEPTH(DEPTH)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .PcIn(PcIn),
        .CacheMissing(CacheMissing),
        .FlushIn(FlushIn),
        .MemArValid(MemArValid),
        .MemArAddr(MemArAddr),
        .MemArReady(MemArReady),
        .MemRValid(MemRValid),
        .MemRData(MemRData),
        .MemRResp(MemRResp),
        .MemRReady(MemRReady),
        .RefillValid(RefillValid),
        .RefillAddr(RefillAddr),
        .RefillInst(RefillInst),
        .RefillBusy(RefillBusy),
        .RefillError(RefillError),
        .DbgState(DbgState)
    );

    // Clock / reset
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkAllZero(input string tag);
        chk({tag, ".arvalid"}, 64'(MemArValid), 64'd0);
        chk({tag, ".araddr"}, MemArAddr, 64'd0);
        chk({tag, ".rready"}, 64'(MemRReady), 64'd0);
        chk({tag, ".refvalid"}, 64'(RefillValid), 64'd0);
        chk({tag, ".refaddr"}, RefillAddr, 64'd0);
        chk({tag, ".refinst"}, 64'(RefillInst), 64'd0);
        chk({tag, ".busy"}, 64'(RefillBusy), 64'd0);
        chk({tag, ".err"}, 64'(RefillError), 64'd0);
    endtask

    // One complete miss. errWord: index of the word answered with an error
    // (-1 none). flushWord: index of the word whose WAIT phase sees a flush
    // before its response (-1 none). holdOff: keep the miss asserted in the
    // cycle the final word is written and expect no restart.
    task automatic runMiss(input string tag, input logic [63:0] pc, input int arDelay,
                           input int rDelay, input int errWord, input int flushWord,
                           input bit holdOff);
        logic [63:0] base;
        logic [63:0] wordAddr;
        logic [31:0] data;
        int          nWords;
        bit          written;
        base   = {pc[63:2], 2'b00};
        nWords = DEPTH;
        if (errWord >= 0) nWords = errWord + 1;
        else if (flushWord >= 0) nWords = flushWord + 1;

        // cycle 0: miss presented in IDLE
        @(negedge Clk);
        PcIn = pc;
        CacheMissing = 1'b1;
        @(negedge Clk);
        CacheMissing = 1'b0;
        for (int k = 0; k < nWords; k++) begin
            wordAddr = base + 64'(4 * k);
            for (int d = 0; d < arDelay; d++) begin
                chk({tag, ".ar_hold_valid"}, 64'(MemArValid), 64'd1);
                chk({tag, ".ar_hold_addr"}, MemArAddr, wordAddr);
                chk({tag, ".ar_hold_rready"}, 64'(MemRReady), 64'd0);
                MemArReady = 1'b0;
                @(negedge Clk);
            end
            chk({tag, ".ar_valid"}, 64'(MemArValid), 64'd1);
            chk({tag, ".ar_addr"}, MemArAddr, wordAddr);
            chk({tag, ".busy"}, 64'(RefillBusy), 64'd1);
            MemArReady = 1'b1;
            // A stray response alongside the address accept must be ignored.
            MemRValid = 1'b1;
            MemRData = 32'hDEAD_BEEF;
            @(negedge Clk);
            MemArReady = 1'b0;
            MemRValid = 1'b0;
            if (flushWord == k) begin
                FlushIn = 1'b1;
                @(negedge Clk);
                FlushIn = 1'b0;
            end
            for (int d = 0; d < rDelay; d++) begin
                chk({tag, ".r_wait_rready"}, 64'(MemRReady), 64'd1);
                chk({tag, ".r_wait_arvalid"}, 64'(MemArValid), 64'd0);
                @(negedge Clk);
            end
            chk({tag, ".rready"}, 64'(MemRReady), 64'd1);
            data = $urandom;
            written = (k != errWord) && (k != flushWord);
            if (written) begin
                exp_q.push_back(wordAddr);
                expInst_q.push_back(data);
            end
            MemRValid = 1'b1;
            MemRData = data;
            MemRResp = (k == errWord) ? 2'b10 : 2'b00;
            @(negedge Clk);
            MemRValid = 1'b0;
            MemRResp = 2'b00;
            MemRData = '0;
            // Cycle after the response: refill pulse (or error pulse).
            if (written) begin
                chk({tag, ".ref_valid"}, 64'(RefillValid), 64'd1);
                if (exp_q.size() > 0) begin
                    chk({tag, ".ref_addr"}, RefillAddr, exp_q.pop_front());
                    chk({tag, ".ref_inst"}, 64'(RefillInst), 64'(expInst_q.pop_front()));
                end
            end else begin
                chk({tag, ".ref_none"}, 64'(RefillValid), 64'd0);
            end
            chk({tag, ".ref_err"}, 64'(RefillError), (k == errWord) ? 64'd1 : 64'd0);
            if (k == nWords - 1) begin
                chk({tag, ".end_busy"}, 64'(RefillBusy), 64'd0);
                chk({tag, ".end_arvalid"}, 64'(MemArValid), 64'd0);
                if (holdOff) begin
                    PcIn = pc;
                    CacheMissing = 1'b1;
                end
            end
        end
        @(negedge Clk);
        CacheMissing = 1'b0;
        chkAllZero({tag, ".idle"});
        repeat (2) @(negedge Clk);
        chk({tag, ".quiet_arvalid"}, 64'(MemArValid), 64'd0);
    endtask

    // Directed sequence
    initial begin
        Rst = 1'b1;
        PcIn = '0;
        CacheMissing = 1'b0;
        FlushIn = 1'b0;
        MemArReady = 1'b0;
        MemRValid = 1'b0;
        MemRData = '0;
        MemRResp = 2'b00;
        repeat (2) @(negedge Clk);
        chkAllZero("reset");
        Rst = 1'b0;
        @(negedge Clk);

        // Basic burst, back-to-back handshakes, last-word hold-off.
        runMiss("basic", 64'h0000_0000_8000_0010, 0, 0, -1, -1, 1'b1);
        // Address channel stalled 5 cycles per word.
        runMiss("arstall", 64'h0000_0000_0040_1234, 5, 1, -1, -1, 1'b0);
        // Flush while waiting for word 1.
        runMiss("flush", 64'h0000_0000_0000_2000, 0, 2, -1, 1, 1'b0);
        // Error response on word 2.
        runMiss("error", 64'h0000_0001_0000_0100, 1, 0, 2, -1, 1'b0);

        // Asynchronous reset while waiting for a response.
        @(negedge Clk);
        PcIn = 64'h0000_0000_0000_3000;
        CacheMissing = 1'b1;
        @(negedge Clk);
        CacheMissing = 1'b0;
        MemArReady = 1'b1;
        @(negedge Clk);
        MemArReady = 1'b0;
        chk("rstwait.rready", 64'(MemRReady), 64'd1);
        chk("rstwait.busy", 64'(RefillBusy), 64'd1);
        #2;
        Rst = 1'b1;
        #1;
        chkAllZero("rstasync");
        MemRValid = 1'b1;
        @(negedge Clk);
        MemRValid = 1'b0;
        Rst = 1'b0;
        @(negedge Clk);
        chkAllZero("rstrelease");
        runMiss("afterrst", 64'h0000_0000_0000_5004, 0, 0, -1, -1, 1'b0);

        // Wrap at the top of the address space.
        runMiss("wrap", 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, -1, -1, 1'b0);

        // Randomized misses against the same reference rules.
        for (int t = 0; t < 6; t++) begin
            logic [63:0] rpc;
            int sel;
            rpc = {$urandom, $urandom};
            sel = $urandom_range(0, 2);
            runMiss("rand", rpc, $urandom_range(0, 3), $urandom_range(0, 3),
                    (sel == 1) ? $urandom_range(0, DEPTH - 1) : -1,
                    (sel == 2) ? $urandom_range(0, DEPTH - 1) : -1, 1'b0);
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
